// File: rtl/jtkcpu_intctl.sv
// jtkcpu_intctl - prioritised interrupt controller for the KCPU core.
//
// Takes NCH asynchronous active-low interrupt lines and synchronises each one.
// Every channel can latch falling edges or follow the line level, and can be
// masked. The controller hands the highest-priority eligible channel to the
// microcode sequencer with an int_req/ack/done handshake. Channel 0 is the
// highest priority. When NMI_CH0=1, channel 0 is non-maskable and stays silent
// until it has been armed.
//
// Optional feature macro: JTKCPU_INTCTL_CNT_EN
//   When defined, int_cnt counts acknowledged interrupts and wraps at 8 bits.
//   When undefined, int_cnt is tied to zero.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   cen        clock enable; no state changes while cen=0
//   int_n      [NCH] active-low interrupt lines (asynchronous)
//   edge_mode  [NCH] 1 = falling-edge latched, 0 = level
//   mask       [NCH] 1 = channel masked (ignored for ch0 when NMI_CH0=1)
//   nmi_arm    one-cycle pulse that arms channel 0
//   ack        sequencer accepts the current request
//   done       sequencer finished the service routine
//   int_req    request pending to the sequencer
//   int_sel    [NCH] one-hot selected channel
//   intvec     [VW] vector index of the selected channel
//   busy       service in progress
//   wake       any synchronised line active, mask ignored
//   int_cnt    [8] acknowledged-interrupt count
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing offered; waiting for an eligible channel
// ST_REQ   | int_req high; the selection follows the live priority winner
// ST_SVC   | acknowledged; the selection is frozen and busy is high until done

module jtkcpu_intctl #(
   parameter int                NCH     = 3,
   parameter int                VW      = 4,
   parameter logic [NCH*VW-1:0] VECTAB  = 12'h86C,
   parameter int                SYNC    = 2,
   parameter bit                NMI_CH0 = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cen,
   input  logic [NCH-1:0] int_n,
   input  logic [NCH-1:0] edge_mode,
   input  logic [NCH-1:0] mask,
   input  logic           nmi_arm,
   input  logic           ack,
   input  logic           done,
   output logic           int_req,
   output logic [NCH-1:0] int_sel,
   output logic [VW-1:0]  intvec,
   output logic           busy,
   output logic           wake,
   output logic [7:0]     int_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SVC
   } state_t;

   state_t         state;
   logic [NCH-1:0] sync_q [SYNC];
   logic [NCH-1:0] line_q;
   logic [NCH-1:0] line_d;
   logic [NCH-1:0] pending;
   logic [NCH-1:0] pend_nx;
   logic [NCH-1:0] fall;
   logic [NCH-1:0] ack_clr;
   logic [NCH-1:0] elig;
   logic [NCH-1:0] sel_oh;
   logic [VW-1:0]  vec_nx;
   logic           any_elig;
   logic           ack_take;
   logic           armed;

   // The synchroniser resets to all ones so that every line starts out inactive.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC; s++) sync_q[s] <= '1;
         line_d <= '1;
      end else if (cen) begin
         sync_q[0] <= int_n;
         for (int s = 1; s < SYNC; s++) sync_q[s] <= sync_q[s-1];
         line_d <= line_q;
      end
   end

   assign line_q   = sync_q[SYNC-1];
   assign fall     = line_d & ~line_q;
   assign wake     = |(~line_q);
   assign ack_take = (state == ST_REQ) && ack;
   assign ack_clr  = ack_ctl(ack_take, int_sel);

   function automatic logic [NCH-1:0] ack_ctl(input logic take, input logic [NCH-1:0] sel);
      return take ? sel : '0;
   endfunction

   // A new edge that arrives on the same cycle as the ack must not be lost,
   // so the set term has priority over the clear term.
   always_comb begin
      pend_nx = pending;
      for (int i = 0; i < NCH; i++) begin
         if (edge_mode[i]) pend_nx[i] = (pending[i] & ~ack_clr[i]) | fall[i];
         else              pend_nx[i] = ~line_q[i];
      end
      if (NMI_CH0 && !armed) pend_nx[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         armed   <= 1'b0;
      end else if (cen) begin
         pending <= pend_nx;
         if (nmi_arm) armed <= 1'b1;
      end
   end

   always_comb begin
      elig = pending & ~mask;
      if (NMI_CH0) elig[0] = pending[0] & armed;
   end

   // Scan from the top index down so that the lowest eligible index wins.
   always_comb begin
      sel_oh = '0;
      vec_nx = '0;
      for (int i = NCH-1; i >= 0; i--) begin
         if (elig[i]) begin
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
            vec_nx    = VECTAB[i*VW +: VW];
         end
      end
   end

   assign any_elig = |elig;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         int_req <= 1'b0;
         int_sel <= '0;
         intvec  <= '0;
         busy    <= 1'b0;
      end else if (cen) begin
         case (state)
            ST_IDLE: begin
               if (any_elig) begin
                  state   <= ST_REQ;
                  int_req <= 1'b1;
                  int_sel <= sel_oh;
                  intvec  <= vec_nx;
               end
            end
            ST_REQ: begin
               if (ack) begin
                  state   <= ST_SVC;
                  int_req <= 1'b0;
                  busy    <= 1'b1;
               end else if (!any_elig) begin
                  state   <= ST_IDLE;
                  int_req <= 1'b0;
                  int_sel <= '0;
                  intvec  <= '0;
               end else begin
                  int_sel <= sel_oh;
                  intvec  <= vec_nx;
               end
            end
            ST_SVC: begin
               if (done) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  int_sel <= '0;
                  intvec  <= '0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               int_req <= 1'b0;
               int_sel <= '0;
               intvec  <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef JTKCPU_INTCTL_CNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)                  cnt_q <= 8'd0;
      else if (cen && ack_take) cnt_q <= cnt_q + 8'd1;
   end

   assign int_cnt = cnt_q;
`else
   assign int_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_jtkcpu_intctl.sv
module tb_jtkcpu_intctl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cen;
   logic [2:0] int_n;
   logic [2:0] edge_mode;
   logic [2:0] mask;
   logic       nmi_arm;
   logic       ack;
   logic       done;
   logic       int_req;
   logic [2:0] int_sel;
   logic [3:0] intvec;
   logic       busy;
   logic       wake;
   logic [7:0] int_cnt;

   typedef struct packed {
      logic [2:0] sel;
      logic [3:0] vec;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb_q [$];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_cnt  = 8'd0;
   logic       busy_prev = 1'b0;

   always #5 clk = ~clk;

   jtkcpu_intctl dut (
      .clk       (clk),
      .rst       (rst),
      .cen       (cen),
      .int_n     (int_n),
      .edge_mode (edge_mode),
      .mask      (mask),
      .nmi_arm   (nmi_arm),
      .ack       (ack),
      .done      (done),
      .int_req   (int_req),
      .int_sel   (int_sel),
      .intvec    (intvec),
      .busy      (busy),
      .wake      (wake),
      .int_cnt   (int_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input logic [2:0] sel, input logic [3:0] vec);
`ifdef JTKCPU_INTCTL_CNT_EN
      exp_cnt = exp_cnt + 8'd1;
`endif
      sb_q.push_back({sel, vec, exp_cnt});
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic do_done();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic wait_req(input string tag, input int maxc);
      int n;
      n = 0;
      while (!int_req && n < maxc) begin
         tick();
         n++;
      end
      check(tag, int_req, 1);
   endtask

   // Compare against the scoreboard when a service starts (busy rises)
   always @(negedge clk) begin
      if (busy && !busy_prev) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            check("sb_sel", int_sel, sb_q[0].sel);
            check("sb_vec", intvec, sb_q[0].vec);
            check("sb_cnt", int_cnt, sb_q[0].cnt);
            void'(sb_q.pop_front());
         end
      end
      busy_prev <= busy;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cen = 1'b1; int_n = 3'b111; edge_mode = 3'b011;
      mask = 3'b000; nmi_arm = 1'b0; ack = 1'b0; done = 1'b0;
      ticks(3);
      check("rst_req", int_req, 0);
      check("rst_sel", int_sel, 0);
      check("rst_vec", intvec, 0);
      check("rst_busy", busy, 0);
      check("rst_wake", wake, 0);
      check("rst_cnt", int_cnt, 0);
      rst = 1'b0;
      tick();

      // channel 0 before arming: the edge is discarded
      int_n[0] = 1'b0;
      ticks(6);
      check("nmi_unarmed", int_req, 0);
      check("nmi_wake", wake, 1);
      int_n[0] = 1'b1;
      ticks(3);
      check("nmi_wake_off", wake, 0);

      nmi_arm = 1'b1;
      tick();
      nmi_arm = 1'b0;
      ticks(2);
      int_n[0] = 1'b0;
      ticks(3);
      check("nmi_lat_early", int_req, 0);
      tick();
      check("nmi_lat", int_req, 1);
      check("nmi_sel", int_sel, 3'b001);
      check("nmi_vec", intvec, 4'hC);
      push(3'b001, 4'hC);
      do_ack();
      check("nmi_busy", busy, 1);
      int_n[0] = 1'b1;
      ticks(2);
      do_done();
      check("nmi_done", busy, 0);
      ticks(3);
      check("nmi_cleared", int_req, 0);

      // level channel 2, then pre-emption by an edge on channel 1
      int_n[2] = 1'b0;
      ticks(3);
      check("lvl_lat_early", int_req, 0);
      tick();
      check("lvl_lat", int_req, 1);
      check("lvl_sel", int_sel, 3'b100);
      check("lvl_vec", intvec, 4'h8);
      int_n[1] = 1'b0;
      ticks(3);
      check("preempt_early", int_sel, 3'b100);
      tick();
      check("preempt_sel", int_sel, 3'b010);
      check("preempt_vec", intvec, 4'h6);
      push(3'b010, 4'h6);
      do_ack();
      check("svc_busy", busy, 1);
      check("svc_req", int_req, 0);
      int_n[1] = 1'b1;
      ticks(3);
      do_done();
      check("done_idle", int_req, 0);
      tick();
      check("ch1_cleared_req", int_req, 1);
      check("ch1_cleared", int_sel, 3'b100);

      // level released before ack: request withdrawn
      int_n[2] = 1'b1;
      ticks(3);
      check("lvl_hold", int_req, 1);
      tick();
      check("lvl_release", int_req, 0);
      check("lvl_rel_busy", busy, 0);
      check("cnt_hold", int_cnt, exp_cnt);

      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ack_idle", busy, 0);

      // masked edge is remembered
      mask = 3'b010;
      int_n[1] = 1'b0;
      ticks(2);
      check("wake_masked", wake, 1);
      tick();
      int_n[1] = 1'b1;
      ticks(2);
      check("wake_masked_off", wake, 0);
      ticks(3);
      check("masked_noreq", int_req, 0);
      mask = 3'b000;
      tick();
      check("unmask_req", int_req, 1);
      check("unmask_vec", intvec, 4'h6);
      push(3'b010, 4'h6);
      do_ack();
      do_done();

      // new edge on the same cycle as the ack of that channel
      tick();
      int_n[1] = 1'b0;
      wait_req("ea_req", 10);
      check("ea_sel", int_sel, 3'b010);
      int_n[1] = 1'b1;
      ticks(3);
      int_n[1] = 1'b0;
      push(3'b010, 4'h6);
      ticks(2);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ea_busy", busy, 1);
      int_n[1] = 1'b1;
      ticks(2);
      do_done();
      tick();
      check("ea_re_req", int_req, 1);
      check("ea_re_sel", int_sel, 3'b010);
      push(3'b010, 4'h6);
      ack = 1'b1; done = 1'b1;
      tick();
      ack = 1'b0; done = 1'b0;
      check("ack_done_both", busy, 1);
      do_done();
      ticks(2);

      // counter wrap
      for (int n = 0; n < 256; n++) begin
         int_n[1] = 1'b0;
         wait_req("loop_req", 10);
         push(3'b010, 4'h6);
         do_ack();
         int_n[1] = 1'b1;
         do_done();
         ticks(2);
      end
      check("cnt_wrap", int_cnt, exp_cnt);

      ticks(2);
      check("sb_drain", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
